stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Stack access sequencer for the 6502 core: owns the stack pointer S and performs 1–3 byte pushes and pulls against page 1 ({8'h01, S}).
- Sits between the control unit and the memory bus arbiter, and serves JSR/RTS/BRK/RTI/PHA/PLA/PHP/PLP.
- Complements the plain load/hold byte registers: those are written; this block consumes and updates S autonomously and reads/writes the memory behind it.

Parameters:
SP_RESET, 8'hFD, value loaded into S on reset
PAGE, 8'h01, high address byte of the stack page

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  stack request present
req_ready  out  1  block accepts request this cycle
req_op  in  1  0 = push, 1 = pull
req_len  in  2  byte count 0..3
req_data  in  24  push bytes; byte k in [8k+7:8k], byte 0 pushed first
rsp_valid  out  1  one-cycle pulse: request complete
rsp_data  out  24  pulled bytes; k-th pulled byte in [8k+7:8k], unused bytes 0
mem_addr  out  16  bus address
mem_wdata  out  8  write data
mem_we  out  1  write strobe, held until mem_ack
mem_re  out  1  read strobe, held until mem_ack
mem_ack  in  1  bus completes access this cycle; mem_rdata valid on reads
mem_rdata  in  8  read data
sp_load  in  1  TXS: load S from sp_in
sp_in  in  8  new S value
sp_out  out  8  current S (TSX, debug)

Behaviour:
Reset (async, rst_n low):
- S = SP_RESET; state IDLE.
- req_ready = 1 after release.
- rsp_valid, mem_we, mem_re = 0; rsp_data = 0; mem_addr = 0; mem_wdata = 0.
- Reset mid-operation aborts the access immediately. Partial pushes are not undone; S keeps no partial result.

States: IDLE, PUSH, PULL_INC, PULL_RD, DONE.

IDLE:
- req_ready = 1 iff not sp_load.
- sp_load: S <= sp_in next edge. sp_load wins over a simultaneous req_valid, which is not accepted that cycle.
- Accept on req_valid & req_ready: latch op, len, data; clear byte counter k and rsp_data.
- len 0 -> DONE (no bus access, S unchanged).
- Push -> PUSH; pull -> PULL_INC.

PUSH:
- mem_addr = {PAGE, S}, mem_wdata = byte k, mem_we = 1.
- On mem_ack: S <= S-1 (mod 256), k++.
- If k+1 == len -> DONE, else stay in PUSH (strobe stays high, new address next cycle).

PULL_INC:
- One cycle, no bus activity: S <= S+1 (mod 256) -> PULL_RD.

PULL_RD:
- mem_addr = {PAGE, S}, mem_re = 1.
- On mem_ack: rsp_data byte k <= mem_rdata, k++.
- If k+1 == len -> DONE, else -> PULL_INC.

DONE:
- rsp_valid = 1 for exactly this cycle; rsp_data is stable from this cycle until the next accept.
- -> IDLE; req_ready = 0 in DONE.

General rules:
- Latency with zero-wait memory: push of n bytes = n+1 cycles after accept; pull of n bytes = 2n+1 cycles.
- Wrap-around: S arithmetic is 8-bit modulo. Push at S=00 writes 0x0100, S->FF. Pull at S=FF reads 0x0100, S->00. No overflow flag.
- sp_load while not IDLE is ignored (control unit must not issue it).
- mem_we and mem_re are never both 1.
- Strobes are deasserted outside PUSH and PULL_RD.
- mem_addr and mem_wdata are stable while a strobe waits for mem_ack.
- sp_out always reflects registered S.

Decomposition:
- Shared package cpu_pkg:
  - stack state enum
  - op encoding constants OP_PUSH=0 and OP_PULL=1
  - STACK_PAGE constant
- The S register reuses the existing general-purpose byte register module (width 8), with the load enable and next-value mux driven by this FSM. No other sub-module.
- Note: the general-purpose register resets to 0, so SP_RESET requires either a reset-value parameter added to it or a local register. Decide with the owner before implementation.

Test Plan:
- Reset with S=SP_RESET: release rst_n -> sp_out=FD, req_ready=1, all strobes 0, rsp_valid=0.
- JSR-style push: len=2, data=24'h00_34_12, mem_ack every cycle -> write 0x01FD=12, then 0x01FC=34; S=FB; rsp_valid pulses 3 cycles after accept.
- RTI-style pull, len=3 from S=FA, memory 01FB=A5, 01FC=00, 01FD=C0, 2-cycle ack delay -> rsp_data=C0_00_A5, S=FD; strobes and addresses held during waits.
- Wrap: sp_load sp_in=00, then push len=1 data=77 -> write 0x0100=77, S=FF; pull len=1 -> read 0x0100, S=00, rsp_data=000077.
- Collision and len 0:
  - sp_load=1 with req_valid=1 in IDLE -> S=sp_in, request not accepted until next cycle.
  - len=0 request -> rsp_valid next cycle, no strobes, S unchanged.
- Reset mid-push: assert rst_n low while mem_we high awaiting ack -> mem_we drops asynchronously, S=FD, state IDLE after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions: stack sequencer states, stack op encoding,
// stack page and the power-on stack pointer value.
package cpu_pkg;

  // High address byte of the hardware stack page.
  localparam logic [7:0] STACK_PAGE = 8'h01;

  // Value the stack pointer takes on reset.
  localparam logic [7:0] SP_RESET_VAL = 8'hFD;

  // Stack request direction, carried on req_op.
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_PULL = 1'b1;

  // Stack sequencer states. A pull pre-increments S in PULL_INC and then
  // reads in PULL_RD, which matches the 6502's empty-descending stack.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH     = 3'd1,
    ST_PULL_INC = 3'd2,
    ST_PULL_RD  = 3'd3,
    ST_DONE     = 3'd4
  } stack_state_e;

  // Select byte k of a 3-byte little-endian word. Byte 3 does not exist
  // and reads as zero.
  function automatic logic [7:0] get_byte(input logic [23:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_reg.sv
// General-purpose load/hold register. RESET_VAL lets a user choose the
// value taken on asynchronous reset; it defaults to zero.
module byte_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  // Load the new value when enabled, otherwise hold.
  always_comb begin
    val_d = val_q;
    if (en) begin
      val_d = d;
    end
  end

  // Storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/stack_ctrl.sv
// Stack access sequencer: owns the stack pointer S and runs 0..3 byte
// pushes and pulls against the stack page through the memory bus.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready. The requester must hold req_op/req_len/req_data
// stable while req_valid is high and not yet accepted. Completion is a
// single-cycle rsp_valid pulse; rsp_data then stays stable until the next
// accepted request. Memory handshake: mem_we or mem_re, with mem_addr and
// mem_wdata, stay asserted and unchanged until the bus returns mem_ack.
module stack_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_VAL,
  parameter logic [7:0] PAGE     = STACK_PAGE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_len,
  input  logic [23:0] req_data,
  output logic        rsp_valid,
  output logic [23:0] rsp_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        sp_load,
  input  logic [7:0]  sp_in,
  output logic [7:0]  sp_out,
  output logic [2:0]  dbg_state
);

  stack_state_e state_q;
  stack_state_e state_d;

  // Latched request. The direction is not stored: the state path taken
  // after acceptance (PUSH vs PULL_INC) already encodes it.
  logic [1:0]  len_q;
  logic [1:0]  len_d;
  logic [23:0] data_q;
  logic [23:0] data_d;
  logic [1:0]  k_q;
  logic [1:0]  k_d;
  logic [23:0] rsp_data_q;
  logic [23:0] rsp_data_d;

  // Stack pointer register interface.
  logic       s_en;
  logic [7:0] s_d;
  logic [7:0] s_q;

  logic accept;
  logic last_byte;

  assign accept    = req_valid & req_ready;
  assign last_byte = ((k_q + 2'd1) == len_q);

  // Stack pointer lives in the shared byte register with a reset value.
  byte_reg #(
    .WIDTH     (8),
    .RESET_VAL (SP_RESET)
  ) u_sp_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s_en),
    .d     (s_d),
    .q     (s_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_len == 2'd0) begin
            state_d = ST_DONE;
          end else if (req_op == OP_PUSH) begin
            state_d = ST_PUSH;
          end else begin
            state_d = ST_PULL_INC;
          end
        end
      end
      ST_PUSH: begin
        if (mem_ack && last_byte) begin
          state_d = ST_DONE;
        end
      end
      ST_PULL_INC: begin
        state_d = ST_PULL_RD;
      end
      ST_PULL_RD: begin
        if (mem_ack) begin
          state_d = last_byte ? ST_DONE : ST_PULL_INC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshakes and the bus access for the current byte.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (state_q)
      ST_IDLE: begin
        // TXS has priority over a request in the same cycle.
        req_ready = ~sp_load;
      end
      ST_PUSH: begin
        mem_we    = 1'b1;
        mem_addr  = {PAGE, s_q};
        mem_wdata = get_byte(data_q, k_q);
      end
      ST_PULL_RD: begin
        mem_re   = 1'b1;
        mem_addr = {PAGE, s_q};
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Request latch, byte counter and pulled-byte assembly.
  always_comb begin
    len_d      = len_q;
    data_d     = data_q;
    k_d        = k_q;
    rsp_data_d = rsp_data_q;
    if ((state_q == ST_IDLE) && accept) begin
      len_d      = req_len;
      data_d     = req_data;
      k_d        = 2'd0;
      rsp_data_d = 24'h000000;
    end else if ((state_q == ST_PUSH) && mem_ack) begin
      k_d = k_q + 2'd1;
    end else if ((state_q == ST_PULL_RD) && mem_ack) begin
      k_d = k_q + 2'd1;
      case (k_q)
        2'd0:    rsp_data_d[7:0]   = mem_rdata;
        2'd1:    rsp_data_d[15:8]  = mem_rdata;
        2'd2:    rsp_data_d[23:16] = mem_rdata;
        default: rsp_data_d        = rsp_data_q;
      endcase
    end
  end

  // Datapath registers; reset clears them so outputs start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= 2'd0;
      data_q     <= 24'h000000;
      k_q        <= 2'd0;
      rsp_data_q <= 24'h000000;
    end else begin
      len_q      <= len_d;
      data_q     <= data_d;
      k_q        <= k_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Stack pointer next value: TXS in IDLE, post-decrement on each pushed
  // byte, pre-increment before each pulled byte. All 8-bit modulo.
  always_comb begin
    s_en = 1'b0;
    s_d  = s_q;
    case (state_q)
      ST_IDLE: begin
        if (sp_load) begin
          s_en = 1'b1;
          s_d  = sp_in;
        end
      end
      ST_PUSH: begin
        if (mem_ack) begin
          s_en = 1'b1;
          s_d  = s_q - 8'd1;
        end
      end
      ST_PULL_INC: begin
        s_en = 1'b1;
        s_d  = s_q + 8'd1;
      end
      default: begin
        s_en = 1'b0;
      end
    endcase
  end

  assign rsp_data  = rsp_data_q;
  assign sp_out    = s_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a byte-array model of the stack page predicts the
// bus transactions, final S and pulled data for directed and random
// requests; a bus responder with programmable ack delay checks them.
module tb_stack_ctrl;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [1:0]  req_len = 2'd0;
  logic [23:0] req_data = 24'h0;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        sp_load = 1'b0;
  logic [7:0]  sp_in = 8'h00;
  logic [7:0]  sp_out;
  logic [2:0]  dbg_state;

  stack_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_len   (req_len),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .sp_load   (sp_load),
    .sp_in     (sp_in),
    .sp_out    (sp_out),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // Expected bus accesses: {we, addr[15:0], wdata (0 for reads)}.
  logic [24:0] exp_q[$];

  logic [7:0] mem     [256];   // memory seen by the bus
  logic [7:0] ref_mem [256];   // model's view of the stack page
  logic [7:0] s_m = 8'hFD;     // model stack pointer
  int         ack_delay = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  int          wait_cnt = 0;
  logic        hold = 1'b0;
  logic [24:0] held = 25'h0;

  always @(negedge clk) begin
    logic [24:0] obs;
    mem_ack = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
      hold = 1'b0;
    end else begin
      chk("strobe_exclusive", {31'h0, mem_we & mem_re}, 32'h0);
      if (mem_we || mem_re) begin
        obs = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
        if (hold) chk("bus_stable", {7'h0, obs}, {7'h0, held});
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_re) mem_rdata = mem[mem_addr[7:0]];
          if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
          if (exp_q.size() == 0) begin
            chk("unexpected_access", {7'h0, obs}, 32'h0);
          end else begin
            chk("bus_access", {7'h0, obs}, {7'h0, exp_q.pop_front()});
          end
          wait_cnt = 0;
          hold = 1'b0;
        end else begin
          wait_cnt++;
          hold = 1'b1;
          held = obs;
        end
      end else begin
        wait_cnt = 0;
        hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic do_sp_load(input logic [7:0] v);
    sp_load = 1'b1;
    sp_in = v;
    @(negedge clk);
    chk("ready_during_load", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    sp_load = 1'b0;
    s_m = v;
    chk("sp_after_load", {24'h0, sp_out}, {24'h0, s_m});
  endtask

  task automatic do_req(input logic op, input logic [1:0] len, input logic [23:0] data,
                        input int d, output logic [23:0] rsp);
    logic [23:0] exp_rsp;
    int lat;
    int exp_lat;
    int guard;
    exp_rsp = 24'h0;
    for (int k = 0; k < int'(len); k++) begin
      if (op == OP_PUSH) begin
        exp_q.push_back({1'b1, STACK_PAGE, s_m, data[8*k +: 8]});
        ref_mem[s_m] = data[8*k +: 8];
        s_m = s_m - 8'd1;
      end else begin
        s_m = s_m + 8'd1;
        exp_q.push_back({1'b0, STACK_PAGE, s_m, 8'h00});
        exp_rsp[8*k +: 8] = ref_mem[s_m];
      end
    end
    if (len == 2'd0)         exp_lat = 1;
    else if (op == OP_PUSH)  exp_lat = int'(len) + 1 + int'(len) * d;
    else                     exp_lat = 2 * int'(len) + 1 + int'(len) * d;
    ack_delay = d;
    req_valid = 1'b1;
    req_op = op;
    req_len = len;
    req_data = data;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("latency", lat, exp_lat);
    chk("rsp_data", {8'h0, rsp_data}, {8'h0, exp_rsp});
    chk("sp_out", {24'h0, sp_out}, {24'h0, s_m});
    chk("all_accesses_done", exp_q.size(), 0);
    chk("strobes_in_done", {30'h0, mem_we, mem_re}, 32'h0);
    chk("ready_in_done", {31'h0, req_ready}, 32'h0);
    rsp = rsp_data;
    @(negedge clk);
    chk("rsp_one_pulse", {31'h0, rsp_valid}, 32'h0);
    chk("rsp_data_hold", {8'h0, rsp_data}, {8'h0, exp_rsp});
    chk("ready_after_done", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [23:0] r;
    int guard;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset state.
    repeat (3) @(posedge clk);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sp", {24'h0, sp_out}, 32'hFD);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_strobes", {29'h0, mem_we, mem_re, rsp_valid}, 32'h0);
    chk("rst_rsp_data", {8'h0, rsp_data}, 32'h0);
    chk("rst_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    @(posedge clk); #1;

    // JSR-style push: 01FD=12, 01FC=34, S=FB, done 3 cycles after accept.
    do_req(OP_PUSH, 2'd2, 24'h003412, 0, r);
    chk("jsr_sp", {24'h0, sp_out}, 32'hFB);

    // RTI-style pull with 2-cycle ack delay.
    do_sp_load(8'hFA);
    mem[8'hFB] = 8'hA5; ref_mem[8'hFB] = 8'hA5;
    mem[8'hFC] = 8'h00; ref_mem[8'hFC] = 8'h00;
    mem[8'hFD] = 8'hC0; ref_mem[8'hFD] = 8'hC0;
    do_req(OP_PULL, 2'd3, 24'h0, 2, r);
    chk("rti_rsp", {8'h0, r}, 32'hC000A5);
    chk("rti_sp", {24'h0, sp_out}, 32'hFD);

    // Wrap-around both ways through 0x0100.
    do_sp_load(8'h00);
    do_req(OP_PUSH, 2'd1, 24'h000077, 0, r);
    chk("wrap_push_sp", {24'h0, sp_out}, 32'hFF);
    do_req(OP_PULL, 2'd1, 24'h0, 0, r);
    chk("wrap_pull_rsp", {8'h0, r}, 32'h000077);
    chk("wrap_pull_sp", {24'h0, sp_out}, 32'h00);

    // TXS collides with a request: load wins, request waits a cycle.
    req_valid = 1'b1; req_op = OP_PUSH; req_len = 2'd1; req_data = 24'h0000AB;
    do_sp_load(8'h40);
    chk("collide_not_accepted", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    do_req(OP_PUSH, 2'd1, 24'h0000AB, 0, r);
    chk("collide_sp", {24'h0, sp_out}, 32'h3F);

    // Zero-length requests: done next cycle, no bus activity, S unchanged.
    do_req(OP_PUSH, 2'd0, 24'h123456, 0, r);
    do_req(OP_PULL, 2'd0, 24'h0, 1, r);
    chk("len0_rsp", {8'h0, r}, 32'h0);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) do_sp_load(8'($urandom));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom),
             int'($urandom_range(0, 2)), r);
    end

    // Reset while a push waits for its ack.
    ack_delay = 10;
    req_valid = 1'b1; req_op = OP_PUSH; req_len = 2'd2; req_data = 24'h00BEEF;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_we && guard < 50);
    chk("midpush_we_seen", {31'h0, mem_we}, 32'h1);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midpush_we_drop", {31'h0, mem_we}, 32'h0);
    chk("midpush_addr", {16'h0, mem_addr}, 32'h0);
    chk("midpush_sp", {24'h0, sp_out}, 32'hFD);
    exp_q.delete();
    s_m = 8'hFD;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    chk("post_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_sp", {24'h0, sp_out}, 32'hFD);
    @(posedge clk); #1;
    do_req(OP_PUSH, 2'd3, 24'h563412, 1, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
